// File: rtl/fpga_host_io_in.sv
// Inbound FPGA host: UART RX -> 14-byte NBF packet -> single-beat BP IO command,
// plus BP IO responses -> NBF reply FIFO toward the outbound UART half.
module fpga_host_io_in #(
    parameter int paddr_width_p      = 40,
    parameter int nbf_addr_width_p   = 40,
    parameter int nbf_data_width_p   = 64,
    parameter int uart_clk_per_bit_p = 10416,
    parameter int uart_data_bits_p   = 8,
    parameter int uart_parity_bit_p  = 0,
    parameter int uart_parity_odd_p  = 0,
    parameter int uart_stop_bits_p   = 1,
    parameter int nbf_buffer_els_p   = 4
) (
    input  logic                                            clk_i,
    input  logic                                            reset_n_i,
    input  logic                                            rx_i,
    output logic [paddr_width_p+6:0]                        io_cmd_header_o,
    output logic [nbf_data_width_p-1:0]                     io_cmd_data_o,
    output logic                                            io_cmd_v_o,
    input  logic                                            io_cmd_yumi_i,
    output logic                                            io_cmd_last_o,
    input  logic [paddr_width_p+6:0]                        io_resp_header_i,
    input  logic [nbf_data_width_p-1:0]                     io_resp_data_i,
    input  logic                                            io_resp_v_i,
    output logic                                            io_resp_ready_and_o,
    input  logic                                            io_resp_last_i,
    output logic [nbf_data_width_p+nbf_addr_width_p+7:0]    nbf_o,
    output logic                                            nbf_v_o,
    input  logic                                            nbf_ready_and_i,
    output logic                                            error_o
);
    localparam int PKT_W     = nbf_data_width_p + nbf_addr_width_p + 8;
    localparam int PKT_BYTES = PKT_W / 8;
    localparam int CNT_W     = $clog2(uart_clk_per_bit_p + 1);
    localparam int OUT_W     = $clog2(nbf_buffer_els_p + 1);
    localparam int PTR_W     = (nbf_buffer_els_p > 1) ? $clog2(nbf_buffer_els_p) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(uart_clk_per_bit_p - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(uart_clk_per_bit_p / 2 - 1);
    localparam logic [2:0] DATA_LAST = 3'(uart_data_bits_p - 1);
    localparam logic [2:0] STOP_LAST = 3'(uart_stop_bits_p - 1);
    localparam bit PAR_EN  = (uart_parity_bit_p != 0);
    localparam bit PAR_ODD = (uart_parity_odd_p != 0);
    localparam logic [3:0] MSG_UC_RD = 4'd2;
    localparam logic [3:0] MSG_UC_WR = 4'd3;
    localparam logic [OUT_W-1:0] ELS = OUT_W'(nbf_buffer_els_p);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    rx_state_t                    rx_state_reg;
    logic                         rx_meta_reg, rx_sync_reg;
    logic [CNT_W-1:0]             clk_cnt_reg;
    logic [2:0]                   bit_idx_reg;
    logic [uart_data_bits_p-1:0]  shift_reg;
    logic                         byte_v_reg, rx_bad_reg, rx_err_reg;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            clk_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            byte_v_reg   <= 1'b0;
            rx_bad_reg   <= 1'b0;
            rx_err_reg   <= 1'b0;
        end else begin
            rx_meta_reg <= rx_i;
            rx_sync_reg <= rx_meta_reg;
            byte_v_reg  <= 1'b0;
            rx_err_reg  <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    clk_cnt_reg <= '0;
                    bit_idx_reg <= '0;
                    rx_bad_reg  <= 1'b0;
                    if (!rx_sync_reg) rx_state_reg <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt_reg == HALF_LAST) begin
                        clk_cnt_reg  <= '0;
                        rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_reg == BIT_LAST) begin
                        clk_cnt_reg <= '0;
                        shift_reg   <= {rx_sync_reg, shift_reg[uart_data_bits_p-1:1]};
                        if (bit_idx_reg == DATA_LAST) begin
                            bit_idx_reg  <= '0;
                            rx_state_reg <= PAR_EN ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                RX_PARITY: begin
                    // A bad parity byte still walks through STOP so the frame ends cleanly.
                    if (clk_cnt_reg == BIT_LAST) begin
                        clk_cnt_reg  <= '0;
                        rx_state_reg <= RX_STOP;
                        if ((^shift_reg ^ rx_sync_reg) != PAR_ODD) begin
                            rx_bad_reg <= 1'b1;
                            rx_err_reg <= 1'b1;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_reg == BIT_LAST) begin
                        clk_cnt_reg <= '0;
                        if (!rx_sync_reg) begin
                            rx_err_reg   <= 1'b1;
                            rx_state_reg <= RX_IDLE;
                        end else if (bit_idx_reg == STOP_LAST) begin
                            byte_v_reg   <= !rx_bad_reg;
                            rx_state_reg <= RX_IDLE;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    logic [PKT_W-1:0]            pkt_reg;
    logic [3:0]                  byte_cnt_reg;
    logic                        pkt_full_reg;
    logic                        cmd_v_reg;
    logic [paddr_width_p+6:0]    cmd_header_reg;
    logic [nbf_data_width_p-1:0] cmd_data_reg;
    logic [OUT_W-1:0]            outstanding_reg;
    logic                        error_reg;
    logic                        ready_reg;
    logic [OUT_W-1:0]            fifo_count_reg, fifo_count_next;
    logic [PTR_W-1:0]            wr_ptr_reg, rd_ptr_reg;
    logic [PKT_W-1:0]            fifo_mem [nbf_buffer_els_p];

    logic [7:0]                  pkt_op;
    logic [nbf_addr_width_p-1:0] pkt_addr;
    logic [nbf_data_width_p-1:0] pkt_data;
    logic is_wr, is_rd, is_cmd, is_sync;
    logic resp_hs, resp_enq, can_issue, sync_enq, bad_op, enq, deq, cmd_hs;
    logic [PKT_W-1:0]            enq_data;

    assign pkt_op    = pkt_reg[7:0];
    assign pkt_addr  = pkt_reg[8 +: nbf_addr_width_p];
    assign pkt_data  = pkt_reg[8 + nbf_addr_width_p +: nbf_data_width_p];
    assign is_wr     = (pkt_op == 8'h02) || (pkt_op == 8'h03);
    assign is_rd     = (pkt_op == 8'h12) || (pkt_op == 8'h13);
    assign is_cmd    = is_wr || is_rd;
    assign is_sync   = (pkt_op == 8'hFE) || (pkt_op == 8'hFF);
    assign resp_hs   = io_resp_v_i && ready_reg;
    assign resp_enq  = resp_hs && (io_resp_header_i[paddr_width_p +: 4] == MSG_UC_RD);
    assign cmd_hs    = cmd_v_reg && io_cmd_yumi_i;
    assign can_issue = pkt_full_reg && is_cmd && !cmd_v_reg && (outstanding_reg < ELS);
    // Responses own the FIFO write port; fence/finish simply retry next cycle.
    assign sync_enq  = pkt_full_reg && is_sync && !cmd_v_reg && (outstanding_reg == '0)
                       && !resp_hs && (fifo_count_reg != ELS);
    assign bad_op    = pkt_full_reg && !is_cmd && !is_sync;
    assign enq       = resp_enq || sync_enq;
    assign deq       = nbf_v_o && nbf_ready_and_i;
    assign fifo_count_next = fifo_count_reg + OUT_W'(enq) - OUT_W'(deq);

    always_comb begin
        enq_data = pkt_reg;
        if (resp_enq) begin
            enq_data = {io_resp_data_i,
                        nbf_addr_width_p'(io_resp_header_i[paddr_width_p-1:0]),
                        (io_resp_header_i[paddr_width_p+4 +: 3] == 3'd3) ? 8'h13 : 8'h12};
        end else if (pkt_op == 8'hFE) begin
            enq_data = {{(PKT_W-8){1'b0}}, 8'hFE};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            pkt_reg         <= '0;
            byte_cnt_reg    <= '0;
            pkt_full_reg    <= 1'b0;
            cmd_v_reg       <= 1'b0;
            cmd_header_reg  <= '0;
            cmd_data_reg    <= '0;
            outstanding_reg <= '0;
            error_reg       <= 1'b0;
            ready_reg       <= 1'b0;
            fifo_count_reg  <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            if (byte_v_reg && !pkt_full_reg) begin
                pkt_reg <= {shift_reg, pkt_reg[PKT_W-1:8]};
                if (byte_cnt_reg == 4'(PKT_BYTES - 1)) begin
                    byte_cnt_reg <= '0;
                    pkt_full_reg <= 1'b1;
                end else begin
                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
                end
            end
            if (can_issue || sync_enq || bad_op) pkt_full_reg <= 1'b0;

            if (can_issue) begin
                cmd_v_reg      <= 1'b1;
                cmd_header_reg <= {pkt_op[0] ? 3'd3 : 3'd2, is_wr ? MSG_UC_WR : MSG_UC_RD,
                                   paddr_width_p'(pkt_addr)};
                cmd_data_reg   <= is_wr ? pkt_data : '0;
            end else if (cmd_hs) begin
                cmd_v_reg <= 1'b0;
            end

            case ({cmd_hs, resp_hs})
                2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
                2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
                default: outstanding_reg <= outstanding_reg;
            endcase

            error_reg      <= error_reg || rx_err_reg || bad_op;
            fifo_count_reg <= fifo_count_next;
            ready_reg      <= (fifo_count_next != ELS);
            if (enq) wr_ptr_reg <= (wr_ptr_reg == PTR_W'(nbf_buffer_els_p - 1)) ? '0 : wr_ptr_reg + 1'b1;
            if (deq) rd_ptr_reg <= (rd_ptr_reg == PTR_W'(nbf_buffer_els_p - 1)) ? '0 : rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) fifo_mem[wr_ptr_reg] <= enq_data;
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, io_resp_last_i};

    assign io_cmd_header_o     = cmd_header_reg;
    assign io_cmd_data_o       = cmd_data_reg;
    assign io_cmd_v_o          = cmd_v_reg;
    assign io_cmd_last_o       = cmd_v_reg;
    assign io_resp_ready_and_o = ready_reg;
    assign nbf_o               = fifo_mem[rd_ptr_reg];
    assign nbf_v_o             = (fifo_count_reg != '0);
    assign error_o             = error_reg;
endmodule

// File: tb/tb_fpga_host_io_in.sv
// Directed bench for fpga_host_io_in at 16 clocks per UART bit; a second
// instance with even parity enabled covers the parity error path.
module tb_fpga_host_io_in;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         rx = 1'b1, rx_p = 1'b1;
    logic [46:0]  cmd_hdr, resp_hdr = '0, cmd_hdr_p;
    logic [63:0]  cmd_data, resp_data = '0, cmd_data_p;
    logic         cmd_v, yumi = 1'b0, cmd_last, resp_v = 1'b0, resp_ready, resp_last = 1'b0;
    logic [111:0] nbf, nbf_p;
    logic         nbf_v, nbf_ready = 1'b0, err;
    logic         cmd_v_p, cmd_last_p, resp_ready_p, nbf_v_p, err_p;
    int           total = 0, bad = 0;

    always #5 clk = ~clk;

    fpga_host_io_in #(.uart_clk_per_bit_p(16)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .rx_i(rx),
        .io_cmd_header_o(cmd_hdr), .io_cmd_data_o(cmd_data), .io_cmd_v_o(cmd_v),
        .io_cmd_yumi_i(yumi), .io_cmd_last_o(cmd_last),
        .io_resp_header_i(resp_hdr), .io_resp_data_i(resp_data), .io_resp_v_i(resp_v),
        .io_resp_ready_and_o(resp_ready), .io_resp_last_i(resp_last),
        .nbf_o(nbf), .nbf_v_o(nbf_v), .nbf_ready_and_i(nbf_ready), .error_o(err));

    fpga_host_io_in #(.uart_clk_per_bit_p(16), .uart_parity_bit_p(1)) dut_p (
        .clk_i(clk), .reset_n_i(reset_n), .rx_i(rx_p),
        .io_cmd_header_o(cmd_hdr_p), .io_cmd_data_o(cmd_data_p), .io_cmd_v_o(cmd_v_p),
        .io_cmd_yumi_i(1'b0), .io_cmd_last_o(cmd_last_p),
        .io_resp_header_i(47'd0), .io_resp_data_i(64'd0), .io_resp_v_i(1'b0),
        .io_resp_ready_and_o(resp_ready_p), .io_resp_last_i(1'b0),
        .nbf_o(nbf_p), .nbf_v_o(nbf_v_p), .nbf_ready_and_i(1'b0), .error_o(err_p));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) tick();
        end
        rx = 1'b1;
        repeat (16) tick();
    endtask

    task automatic send_byte_p(input logic [7:0] b, input logic par);
        rx_p = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            rx_p = b[i];
            repeat (16) tick();
        end
        rx_p = par;
        repeat (16) tick();
        rx_p = 1'b1;
        repeat (16) tick();
    endtask

    task automatic send_pkt(input logic [7:0] op, input logic [39:0] addr,
                            input logic [63:0] data, input int nbytes);
        logic [111:0] p;
        p = {data, addr, op};
        for (int i = 0; i < nbytes; i++) send_byte(p[i*8 +: 8]);
    endtask

    task automatic wait_cmd;
        for (int i = 0; i < 100 && !cmd_v; i++) tick();
    endtask

    task automatic take_cmd;
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
    endtask

    task automatic respond(input logic [3:0] msg, input logic [2:0] size,
                           input logic [39:0] addr, input logic [63:0] data);
        resp_hdr  = {size, msg, addr};
        resp_data = data;
        resp_v    = 1'b1;
        for (int i = 0; i < 20 && !resp_ready; i++) tick();
        tick();
        resp_v = 1'b0;
    endtask

    task automatic pop;
        nbf_ready = 1'b1;
        tick();
        nbf_ready = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [39:0] addr);
        send_pkt(8'h03, addr, 64'h0, 14);
        wait_cmd();
        chk(tag, cmd_v, 1'b1);
        take_cmd();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_cmd_v", cmd_v, 1'b0);
        chk("rst_nbf_v", nbf_v, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_resp_ready", resp_ready, 1'b0);
        reset_n = 1'b1;
        tick();
        chk("resp_ready_up", resp_ready, 1'b1);

        // 8-byte write
        send_pkt(8'h03, 40'h0080001000, 64'h12345678DEADBEEF, 14);
        wait_cmd();
        chk("wr_v", cmd_v, 1'b1);
        chk("wr_hdr", cmd_hdr, {3'd3, 4'd3, 40'h0080001000});
        chk("wr_data", cmd_data, 64'h12345678DEADBEEF);
        chk("wr_last", cmd_last, 1'b1);
        repeat (5) tick();
        chk("wr_hold", {cmd_v, cmd_hdr}, {1'b1, 3'd3, 4'd3, 40'h0080001000});
        take_cmd();
        chk("wr_v_drop", cmd_v, 1'b0);
        respond(4'd3, 3'd3, 40'h0080001000, 64'h0);
        repeat (10) tick();
        chk("wr_no_reply", nbf_v, 1'b0);

        // 8-byte read
        send_pkt(8'h13, 40'h0080001000, 64'hFFFF_FFFF_FFFF_FFFF, 14);
        wait_cmd();
        chk("rd_hdr", cmd_hdr, {3'd3, 4'd2, 40'h0080001000});
        chk("rd_data", cmd_data, 64'h0);
        take_cmd();
        respond(4'd2, 3'd3, 40'h0080001000, 64'hCAFEF00D11223344);
        tick();
        chk("rd_nbf_v", nbf_v, 1'b1);
        chk("rd_nbf", nbf, {64'hCAFEF00D11223344, 40'h0080001000, 8'h13});
        pop();
        chk("rd_nbf_empty", nbf_v, 1'b0);

        // credit limit: 4 in flight, 5th waits for a response
        for (int i = 0; i < 4; i++) do_write($sformatf("credit_w%0d", i), 40'h100 + 40'(i));
        send_pkt(8'h02, 40'h200, 64'h5, 14);
        repeat (30) tick();
        chk("credit_stall", cmd_v, 1'b0);
        respond(4'd3, 3'd3, 40'h100, 64'h0);
        wait_cmd();
        chk("credit_release", {cmd_v, cmd_hdr}, {1'b1, 3'd2, 4'd3, 40'h200});
        chk("credit_data", cmd_data, 64'h5);
        take_cmd();
        for (int i = 0; i < 4; i++) respond(4'd3, 3'd3, 40'h0, 64'h0);
        repeat (4) tick();
        chk("credit_no_reply", nbf_v, 1'b0);

        // fence behind two writes
        do_write("fence_w0", 40'h300);
        do_write("fence_w1", 40'h308);
        send_pkt(8'hFE, 40'h55, 64'h77, 14);
        repeat (30) tick();
        chk("fence_wait0", nbf_v, 1'b0);
        respond(4'd3, 3'd3, 40'h300, 64'h0);
        repeat (10) tick();
        chk("fence_wait1", nbf_v, 1'b0);
        respond(4'd3, 3'd3, 40'h308, 64'h0);
        repeat (4) tick();
        chk("fence_v", nbf_v, 1'b1);
        chk("fence_nbf", nbf, {64'h0, 40'h0, 8'hFE});
        pop();

        // finish behind two writes
        do_write("fin_w0", 40'h400);
        do_write("fin_w1", 40'h408);
        send_pkt(8'hFF, 40'h123, 64'h1, 14);
        repeat (30) tick();
        chk("fin_wait", nbf_v, 1'b0);
        respond(4'd3, 3'd3, 40'h400, 64'h0);
        respond(4'd3, 3'd3, 40'h408, 64'h0);
        repeat (4) tick();
        chk("fin_nbf", {nbf_v, nbf}, {1'b1, 64'h1, 40'h123, 8'hFF});
        pop();

        // unknown opcode
        chk("err_before", err, 1'b0);
        send_pkt(8'h55, 40'h1, 64'h2, 14);
        repeat (5) tick();
        chk("bad_op_err", err, 1'b1);
        chk("bad_op_no_cmd", cmd_v, 1'b0);
        repeat (50) tick();
        chk("err_sticky", err, 1'b1);

        // reset in the middle of a packet
        send_pkt(8'h03, 40'hAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB, 7);
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("mid_rst_err", err, 1'b0);
        send_pkt(8'h03, 40'h00000A0B0C, 64'h0102030405060708, 14);
        wait_cmd();
        chk("mid_rst_hdr", {cmd_v, cmd_hdr}, {1'b1, 3'd3, 4'd3, 40'h00000A0B0C});
        chk("mid_rst_data", cmd_data, 64'h0102030405060708);
        take_cmd();
        repeat (40) tick();
        chk("mid_rst_single", cmd_v, 1'b0);
        chk("mid_rst_err2", err, 1'b0);

        // even parity on the second instance
        send_byte_p(8'h01, 1'b1);
        repeat (4) tick();
        chk("par_ok", err_p, 1'b0);
        send_byte_p(8'h01, 1'b0);
        repeat (4) tick();
        chk("par_bad", err_p, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
